// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write-port arbiter: one holding entry per requester,
// round-robin on conflict, registered one-hot write enables/data/grant.
module regfile_write_arbiter #(
    parameter int unsigned N = 32,
    parameter int unsigned R = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         req0_valid,
    input  logic [4:0]   req0_addr,
    input  logic [N-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [4:0]   req1_addr,
    input  logic [N-1:0] req1_data,
    output logic         req1_ready,
    output logic [R-1:0] wr_en,
    output logic [N-1:0] wr_data,
    output logic [1:0]   grant
);

    localparam int unsigned AW = 5;

    typedef enum logic {
        PRIO0 = 1'b0,
        PRIO1 = 1'b1
    } prio_e;

    prio_e          r_state;
    prio_e          w_state_nxt;

    logic           r_hold_v0;
    logic           r_hold_v1;
    logic [AW-1:0]  r_hold_addr0;
    logic [AW-1:0]  r_hold_addr1;
    logic [N-1:0]   r_hold_data0;
    logic [N-1:0]   r_hold_data1;

    logic           w_sel0;
    logic           w_sel1;
    logic           w_xfer0;
    logic           w_xfer1;
    logic [AW-1:0]  w_wr_addr;
    logic [N-1:0]   w_wr_data;
    logic [R-1:0]   w_wr_en;

    // Priority state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= PRIO0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration over held entries only; priority rotates only on a conflict
    always_comb begin
        w_state_nxt = r_state;
        w_sel0      = 1'b0;
        w_sel1      = 1'b0;
        case ({r_hold_v1, r_hold_v0})
            2'b01: w_sel0 = 1'b1;
            2'b10: w_sel1 = 1'b1;
            2'b11: begin
                if (r_state == PRIO0) begin
                    w_sel0      = 1'b1;
                    w_state_nxt = PRIO1;
                end else begin
                    w_sel1      = 1'b1;
                    w_state_nxt = PRIO0;
                end
            end
            default: ;
        endcase
    end

    assign req0_ready = (!r_hold_v0 || w_sel0) && !clr;
    assign req1_ready = (!r_hold_v1 || w_sel1) && !clr;
    assign w_xfer0    = req0_valid && req0_ready;
    assign w_xfer1    = req1_valid && req1_ready;

    assign w_wr_addr = w_sel0 ? r_hold_addr0 : r_hold_addr1;
    assign w_wr_data = w_sel0 ? r_hold_data0 : r_hold_data1;
    // Register 0 is hardwired: the write is consumed but never enabled
    assign w_wr_en   = ((w_sel0 || w_sel1) && (w_wr_addr != AW'(0)))
                       ? (R'(1) << w_wr_addr) : R'(0);

    // Holding entries: a refill in the same cycle as a grant keeps the entry valid
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hold_v0    <= 1'b0;
            r_hold_v1    <= 1'b0;
            r_hold_addr0 <= '0;
            r_hold_addr1 <= '0;
            r_hold_data0 <= '0;
            r_hold_data1 <= '0;
        end else begin
            if (w_xfer0) begin
                r_hold_v0    <= 1'b1;
                r_hold_addr0 <= req0_addr;
                r_hold_data0 <= req0_data;
            end else if (w_sel0) begin
                r_hold_v0    <= 1'b0;
            end
            if (w_xfer1) begin
                r_hold_v1    <= 1'b1;
                r_hold_addr1 <= req1_addr;
                r_hold_data1 <= req1_data;
            end else if (w_sel1) begin
                r_hold_v1    <= 1'b0;
            end
        end
    end

    // Write-port outputs; wr_data keeps its last value when idle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_en   <= '0;
            wr_data <= '0;
            grant   <= 2'b00;
        end else begin
            wr_en <= w_wr_en;
            grant <= {w_sel1, w_sel0};
            if (w_sel0 || w_sel1) begin
                wr_data <= w_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle vector table for ready/grant plus
// per-requester scoreboards for the issued write enables and data.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        clr;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [31:0] wr_en;
    logic [31:0] wr_data;
    logic [1:0]  grant;

    regfile_write_arbiter #(.N(32), .R(32)) dut (
        .clk        (clk),
        .clr        (clr),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic [1:0]  g;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t        tbl[$];
    wr_t         q0[$];
    wr_t         q1[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_data = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic r0, input logic r1, input logic [1:0] g);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.g = g;
        tbl.push_back(v);
    endfunction

    function automatic void idle(input logic r0, input logic r1, input logic [1:0] g);
        add(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r0, r1, g);
    endfunction

    // Compare the write port against the scoreboard entry of the granted source
    task automatic check_out();
        wr_t         e;
        logic [31:0] exp_en;
        chk("wr_en_onehot", 32'($countones(wr_en) <= 1), 32'd1);
        case (grant)
            2'b01, 2'b10: begin
                if ((grant == 2'b01 && q0.size() == 0) || (grant == 2'b10 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty actual grant=%b required=no write", grant);
                end else begin
                    e = (grant == 2'b01) ? q0.pop_front() : q1.pop_front();
                    exp_en = (e.a == 5'd0) ? 32'd0 : (32'd1 << e.a);
                    chk("wr_en", wr_en, exp_en);
                    chk("wr_data", wr_data, e.d);
                    last_data = e.d;
                end
            end
            2'b00: begin
                chk("wr_en_idle", wr_en, 32'd0);
                chk("wr_data_hold", wr_data, last_data);
            end
            default: chk("grant_onehot", 32'(grant), 32'd0);
        endcase
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
        req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
        #1;
        chk("req0_ready", 32'(req0_ready), 32'(v.r0));
        chk("req1_ready", 32'(req1_ready), 32'(v.r1));
        chk("grant", 32'(grant), 32'(v.g));
        check_out();
        if (req0_valid && req0_ready) q0.push_back({req0_addr, req0_data});
        if (req1_valid && req1_ready) q1.push_back({req1_addr, req1_data});
    endtask

    initial begin
        vec_t v;
        clr = 1'b1;
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;

        // Single write to r5
        add(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 2'b00);
        idle(1'b1, 1'b1, 2'b00);
        idle(1'b1, 1'b1, 2'b01);
        idle(1'b1, 1'b1, 2'b00);
        // Conflict from PRIO0: requester 0 first, requester 1 stalls one cycle
        add(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1'b1, 2'b00);
        idle(1'b1, 1'b0, 2'b00);
        idle(1'b1, 1'b1, 2'b01);
        idle(1'b1, 1'b1, 2'b10);
        idle(1'b1, 1'b1, 2'b00);
        // Saturation starting in PRIO1; each requester holds its word until accepted
        add(1'b1, 5'd10, 32'hA0, 1'b1, 5'd20, 32'hB0, 1'b1, 1'b1, 2'b00);
        add(1'b1, 5'd11, 32'hA1, 1'b1, 5'd21, 32'hB1, 1'b0, 1'b1, 2'b00);
        add(1'b1, 5'd11, 32'hA1, 1'b1, 5'd22, 32'hB2, 1'b1, 1'b0, 2'b10);
        add(1'b1, 5'd12, 32'hA2, 1'b1, 5'd22, 32'hB2, 1'b0, 1'b1, 2'b01);
        add(1'b1, 5'd12, 32'hA2, 1'b1, 5'd23, 32'hB3, 1'b1, 1'b0, 2'b10);
        add(1'b1, 5'd13, 32'hA3, 1'b1, 5'd23, 32'hB3, 1'b0, 1'b1, 2'b01);
        add(1'b1, 5'd13, 32'hA3, 1'b1, 5'd24, 32'hB4, 1'b1, 1'b0, 2'b10);
        add(1'b1, 5'd14, 32'hA4, 1'b1, 5'd24, 32'hB4, 1'b0, 1'b1, 2'b01);
        idle(1'b1, 1'b0, 2'b10);
        idle(1'b1, 1'b1, 2'b01);
        idle(1'b1, 1'b1, 2'b10);
        idle(1'b1, 1'b1, 2'b00);
        // Register 0 write: granted, consumed, no enable
        add(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b1, 1'b1, 2'b00);
        idle(1'b1, 1'b1, 2'b00);
        idle(1'b1, 1'b1, 2'b10);
        idle(1'b1, 1'b1, 2'b00);
        // Back-to-back single requester
        add(1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 2'b00);
        add(1'b1, 5'd2, 32'h102, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 2'b00);
        add(1'b1, 5'd3, 32'h103, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 2'b01);
        add(1'b1, 5'd4, 32'h104, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 2'b01);
        idle(1'b1, 1'b1, 2'b01);
        idle(1'b1, 1'b1, 2'b01);
        idle(1'b1, 1'b1, 2'b00);

        #3;
        chk("rst_wr_en", wr_en, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Mid-flight reset with both entries held and FSM in PRIO1
        v = '0; v.v0 = 1'b1; v.a0 = 5'd7; v.d0 = 32'h77; v.v1 = 1'b1; v.a1 = 5'd8; v.d1 = 32'h88;
        v.r0 = 1'b1; v.r1 = 1'b1; v.g = 2'b00;
        apply(v);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("pre_clr_ready0", 32'(req0_ready), 32'd0);
        chk("pre_clr_ready1", 32'(req1_ready), 32'd1);
        chk("pre_clr_wr_data", wr_data, 32'h104);
        #1 clr = 1'b1;
        #1;
        chk("clr_wr_en", wr_en, 32'd0);
        chk("clr_wr_data", wr_data, 32'd0);
        chk("clr_grant", 32'(grant), 32'd0);
        chk("clr_ready0", 32'(req0_ready), 32'd0);
        chk("clr_ready1", 32'(req1_ready), 32'd0);
        #1 clr = 1'b0;
        q0.delete();
        q1.delete();
        last_data = 32'd0;

        v = '0; v.r0 = 1'b1; v.r1 = 1'b1; v.g = 2'b00;
        for (int i = 0; i < 3; i++) apply(v);
        // First post-reset conflict goes to requester 0; same address, later grant is final
        v.v0 = 1'b1; v.a0 = 5'd9; v.d0 = 32'h99; v.v1 = 1'b1; v.a1 = 5'd9; v.d1 = 32'hAA;
        apply(v);
        v = '0; v.r0 = 1'b1; v.r1 = 1'b0; v.g = 2'b00;
        apply(v);
        v.r1 = 1'b1; v.g = 2'b01;
        apply(v);
        v.g = 2'b10;
        apply(v);
        v.g = 2'b00;
        apply(v);
        chk("same_addr_final", wr_data, 32'hAA);
        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
